// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 pointer path: packet FSM states, status-byte
// bit positions, packet lengths and the 9-bit delta decoder.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    UPDATE
  } ps2_state_e;

  typedef enum int unsigned {
    ST_LEFT  = 0,
    ST_RIGHT = 1,
    ST_MID   = 2,
    ST_SYNC  = 3,
    ST_XSIGN = 4,
    ST_YSIGN = 5,
    ST_XOVF  = 6,
    ST_YOVF  = 7
  } status_bit_e;

  typedef enum int unsigned {
    PKT_LEN_STD   = 3,
    PKT_LEN_WHEEL = 4
  } pkt_len_e;

  // An overflowed axis reports the extreme value in the direction of its sign bit.
  function automatic logic signed [8:0] delta9(input logic sign, input logic ovf,
                                               input logic [7:0] mag);
    if (ovf) return sign ? 9'sh100 : 9'sh0FF;
    return signed'({sign, mag});
  endfunction

endpackage

// File: rtl/ps2_pointer_tracker_if.sv
// Byte stream from the PS/2 mouse receiver into the pointer tracker.
interface ps2_pointer_tracker_if;
  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic       BYTE_ERROR;

  modport master (output BYTE_IN, output BYTE_VALID, output BYTE_ERROR);
  modport slave  (input  BYTE_IN, input  BYTE_VALID, input  BYTE_ERROR);
endinterface

// File: rtl/ps2_axis_accum.sv
// One pointer axis: decodes a PS/2 delta, scales it and accumulates into a
// position clamped to 0..limit-1 (CLAMP_EN=1) or saturated as signed W bits.
module ps2_axis_accum
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned W          = 10,
  parameter int unsigned SENS_SHIFT = 0,
  parameter bit          CLAMP_EN   = 1'b1,
  parameter bit          NEGATE     = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic         centre,
  input  logic         sign_in,
  input  logic         ovf_in,
  input  logic [7:0]   mag_in,
  input  logic [W-1:0] limit,
  output logic [W-1:0] pos
);
  localparam int unsigned SW = W + SENS_SHIFT + 2;
  localparam logic signed [SW-1:0] ZMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] ZMIN = ~ZMAX;

  logic [W-1:0]          pos_q, pos_d;
  logic [W-1:0]          hi, home, upd;
  logic signed [8:0]     d9;
  logic signed [SW-1:0]  ext_s, delta_s, cur_s, sum_s, hi_s;

  always_comb begin
    hi    = (limit == '0) ? '0 : limit - 1'b1;
    home  = CLAMP_EN ? (limit >> 1) : '0;
    hi_s  = {{(SW-W){1'b0}}, hi};
    d9    = delta9(sign_in, ovf_in, mag_in);
    ext_s = {{(SW-9){d9[8]}}, d9};
    delta_s = ext_s <<< SENS_SHIFT;
    if (CLAMP_EN) cur_s = {{(SW-W){1'b0}}, pos_q};
    else          cur_s = {{(SW-W){pos_q[W-1]}}, pos_q};
    sum_s = NEGATE ? (cur_s - delta_s) : (cur_s + delta_s);

    if (CLAMP_EN) begin
      if (sum_s[SW-1])      upd = '0;
      else if (sum_s > hi_s) upd = hi;
      else                  upd = sum_s[W-1:0];
    end else begin
      if (sum_s > ZMAX)      upd = ZMAX[W-1:0];
      else if (sum_s < ZMIN) upd = ZMIN[W-1:0];
      else                   upd = sum_s[W-1:0];
    end

    // Centring beats a packet update; a shrunk limit pulls the position in.
    pos_d = pos_q;
    if (centre)                     pos_d = home;
    else if (load)                  pos_d = upd;
    else if (CLAMP_EN && pos_q > hi) pos_d = hi;
  end

  always_ff @(posedge CLK) begin
    if (RESET) pos_q <= home;
    else       pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

// File: rtl/ps2_pointer_tracker.sv
// PS/2 packet assembler with sync/timeout checking feeding saturated X/Y/Z
// position accumulators; INTR pulses once per accepted packet.
module ps2_pointer_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned Z_W         = 8,
  parameter bit          WHEEL_EN    = 1'b0,
  parameter int unsigned SENS_SHIFT  = 0,
  parameter bit          INVERT_Y    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic               CLK,
  input  logic               RESET,
  ps2_pointer_tracker_if.slave rx,
  input  logic [COORD_W-1:0] LIMIT_X,
  input  logic [COORD_W-1:0] LIMIT_Y,
  input  logic               CENTRE,
  output logic [COORD_W-1:0] MOUSE_X,
  output logic [COORD_W-1:0] MOUSE_Y,
  output logic [Z_W-1:0]     MOUSE_Z,
  output logic [7:0]         MOUSE_STATUS,
  output logic               INTR,
  output logic               SYNC_ERR
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    b0_q, b0_d, dx_q, dx_d, dy_q, dy_d, status_q, status_d;
  logic          intr_q, sync_err_q, sync_err_d;
  logic          load;
  logic [7:0]    dy_src;
  logic [3:0]    dz_nib;

  // The final byte feeds the accumulators directly so results land on the
  // UPDATE cycle itself, one cycle after the last strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    b0_d       = b0_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    status_d   = status_q;
    sync_err_d = 1'b0;
    load       = 1'b0;
    dy_src     = dy_q;
    dz_nib     = '0;
    unique case (state_q)
      WAIT_B0: begin
        if (rx.BYTE_ERROR || (rx.BYTE_VALID && !rx.BYTE_IN[ST_SYNC])) sync_err_d = 1'b1;
        else if (rx.BYTE_VALID) begin
          b0_d    = rx.BYTE_IN;
          state_d = WAIT_B1;
        end
      end
      UPDATE: state_d = WAIT_B0;
      default: begin
        if (rx.BYTE_ERROR) begin
          state_d    = WAIT_B0;
          sync_err_d = 1'b1;
        end else if (rx.BYTE_VALID) begin
          unique case (state_q)
            WAIT_B1: begin
              dx_d    = rx.BYTE_IN;
              state_d = WAIT_B2;
            end
            WAIT_B2: begin
              dy_d = rx.BYTE_IN;
              if (WHEEL_EN) state_d = WAIT_B3;
              else begin
                dy_src  = rx.BYTE_IN;
                load    = 1'b1;
                state_d = UPDATE;
              end
            end
            default: begin
              dz_nib  = rx.BYTE_IN[3:0];
              load    = 1'b1;
              state_d = UPDATE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_LIM) begin
            cnt_d      = '0;
            state_d    = WAIT_B0;
            sync_err_d = 1'b1;
          end
        end
      end
    endcase
    if (load) status_d = b0_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= WAIT_B0;
      cnt_q      <= '0;
      b0_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      status_q   <= '0;
      intr_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b0_q       <= b0_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      status_q   <= status_d;
      intr_q     <= load;
      sync_err_q <= sync_err_d;
    end
  end

  ps2_axis_accum #(.W(COORD_W), .SENS_SHIFT(SENS_SHIFT), .CLAMP_EN(1'b1), .NEGATE(1'b0)) u_x (
    .CLK(CLK), .RESET(RESET), .load(load), .centre(CENTRE),
    .sign_in(b0_q[ST_XSIGN]), .ovf_in(b0_q[ST_XOVF]), .mag_in(dx_q),
    .limit(LIMIT_X), .pos(MOUSE_X)
  );

  ps2_axis_accum #(.W(COORD_W), .SENS_SHIFT(SENS_SHIFT), .CLAMP_EN(1'b1), .NEGATE(INVERT_Y)) u_y (
    .CLK(CLK), .RESET(RESET), .load(load), .centre(CENTRE),
    .sign_in(b0_q[ST_YSIGN]), .ovf_in(b0_q[ST_YOVF]), .mag_in(dy_src),
    .limit(LIMIT_Y), .pos(MOUSE_Y)
  );

  ps2_axis_accum #(.W(Z_W), .SENS_SHIFT(SENS_SHIFT), .CLAMP_EN(1'b0), .NEGATE(1'b0)) u_z (
    .CLK(CLK), .RESET(RESET), .load(load), .centre(CENTRE),
    .sign_in(dz_nib[3]), .ovf_in(1'b0), .mag_in({{4{dz_nib[3]}}, dz_nib}),
    .limit('0), .pos(MOUSE_Z)
  );

  assign MOUSE_STATUS = status_q;
  assign INTR         = intr_q;
  assign SYNC_ERR     = sync_err_q;

endmodule

// File: tb/tb_ps2_pointer_tracker.sv
// Bench for ps2_pointer_tracker: a standard 3-byte instance and a wheel instance
// driven with directed and random packets against an arithmetic position model.
module tb_ps2_pointer_tracker;
  localparam int unsigned CW = 10;
  localparam int unsigned ZW = 8;
  localparam int unsigned TO = 40;
  localparam int unsigned SH = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] lim_x, lim_y;
  logic          centre;
  logic [CW-1:0] sx, sy, wx_o, wy_o;
  logic [ZW-1:0] sz, wz_o;
  logic [7:0]    sst, wst;
  logic          sintr, ssync, wintr, wsync;

  ps2_pointer_tracker_if ifs ();
  ps2_pointer_tracker_if ifw ();

  always #5 clk = ~clk;

  ps2_pointer_tracker #(.COORD_W(CW), .Z_W(ZW), .WHEEL_EN(1'b0), .SENS_SHIFT(SH),
                        .INVERT_Y(1'b1), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RESET(rst), .rx(ifs), .LIMIT_X(lim_x), .LIMIT_Y(lim_y), .CENTRE(centre),
    .MOUSE_X(sx), .MOUSE_Y(sy), .MOUSE_Z(sz), .MOUSE_STATUS(sst), .INTR(sintr), .SYNC_ERR(ssync)
  );

  ps2_pointer_tracker #(.COORD_W(CW), .Z_W(ZW), .WHEEL_EN(1'b1), .SENS_SHIFT(SH),
                        .INVERT_Y(1'b1), .TIMEOUT_CYC(TO)) dutw (
    .CLK(clk), .RESET(rst), .rx(ifw), .LIMIT_X(lim_x), .LIMIT_Y(lim_y), .CENTRE(centre),
    .MOUSE_X(wx_o), .MOUSE_Y(wy_o), .MOUSE_Z(wz_o), .MOUSE_STATUS(wst), .INTR(wintr), .SYNC_ERR(wsync)
  );

  int errors = 0;
  int checks = 0;
  int mx, my, mz, wx, wy, wz;
  logic [7:0] ms, ws;

  function automatic int dlt(input logic s, input logic o, input logic [7:0] m);
    if (o) return s ? -256 : 255;
    return s ? int'(m) - 256 : int'(m);
  endfunction

  function automatic int clampv(input int v, input int lim);
    if (lim <= 0) return 0;
    if (v < 0) return 0;
    if (v > lim - 1) return lim - 1;
    return v;
  endfunction

  function automatic void model_home();
    mx = int'(lim_x) / 2; my = int'(lim_y) / 2; mz = 0; ms = 8'h00;
    wx = int'(lim_x) / 2; wy = int'(lim_y) / 2; wz = 0; ws = 8'h00;
  endfunction

  function automatic void model_pkt(input bit w, input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
    int dx = dlt(b0[4], b0[6], b1) * (1 << SH);
    int dy = dlt(b0[5], b0[7], b2) * (1 << SH);
    int dz = (b3[3] ? int'(b3[3:0]) - 16 : int'(b3[3:0])) * (1 << SH);
    if (!w) begin
      mx = clampv(mx + dx, int'(lim_x));
      my = clampv(my - dy, int'(lim_y));
      ms = b0;
    end else begin
      wx = clampv(wx + dx, int'(lim_x));
      wy = clampv(wy - dy, int'(lim_y));
      wz = wz + dz;
      if (wz > 127) wz = 127;
      if (wz < -128) wz = -128;
      ws = b0;
    end
  endfunction

  task automatic send_byte(input bit w, input logic [7:0] b, input logic v, input logic e);
    if (w) begin ifw.BYTE_IN = b; ifw.BYTE_VALID = v; ifw.BYTE_ERROR = e; end
    else   begin ifs.BYTE_IN = b; ifs.BYTE_VALID = v; ifs.BYTE_ERROR = e; end
    @(negedge clk);
    ifs.BYTE_VALID = 1'b0; ifs.BYTE_ERROR = 1'b0;
    ifw.BYTE_VALID = 1'b0; ifw.BYTE_ERROR = 1'b0;
  endtask

  // Returns at the sample point of the UPDATE cycle.
  task automatic send_pkt(input bit w, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    send_byte(w, b0, 1'b1, 1'b0);
    send_byte(w, b1, 1'b1, 1'b0);
    send_byte(w, b2, 1'b1, 1'b0);
    if (w) send_byte(w, b3, 1'b1, 1'b0);
    model_pkt(w, b0, b1, b2, w ? b3 : 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_home();
  endtask

  task automatic test_reset();
    lim_x = 10'd640; lim_y = 10'd480;
    do_reset();
    checks++;
    if ({sx, sy, sz, sst, sintr, ssync} !== {10'd320, 10'd240, 8'd0, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_std: got x=%0d y=%0d z=%0d st=%h intr=%b sync=%b want 320 240 0 00 0 0",
               sx, sy, sz, sst, sintr, ssync);
    end
    checks++;
    if ({wx_o, wy_o, wz_o, wst, wintr, wsync} !== {10'd320, 10'd240, 8'd0, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_wheel: got x=%0d y=%0d z=%0d st=%h intr=%b sync=%b want 320 240 0 00 0 0",
               wx_o, wy_o, wz_o, wst, wintr, wsync);
    end
  endtask

  task automatic test_basic();
    send_byte(1'b0, 8'h08, 1'b1, 1'b0);
    send_byte(1'b0, 8'h10, 1'b1, 1'b0);
    checks++;
    if (sintr !== 1'b0) begin errors++; $display("FAIL early_intr: got %b want 0", sintr); end
    send_byte(1'b0, 8'h05, 1'b1, 1'b0);
    model_pkt(1'b0, 8'h08, 8'h10, 8'h05, 8'h00);
    checks++;
    if ({sintr, sx, sy, sst} !== {1'b1, 10'd336, 10'd235, 8'h08}) begin
      errors++;
      $display("FAIL basic_pkt: got intr=%b x=%0d y=%0d st=%h want 1 336 235 08", sintr, sx, sy, sst);
    end
    @(negedge clk);
    checks++;
    if (sintr !== 1'b0) begin errors++; $display("FAIL intr_width: got %b want 0", sintr); end
  endtask

  task automatic test_overflow();
    send_pkt(1'b0, 8'h08, 8'hFF, 8'h00, 8'h00);
    @(negedge clk);
    send_pkt(1'b0, 8'h08, 8'h27, 8'h00, 8'h00);
    checks++;
    if (sx !== 10'd630) begin errors++; $display("FAIL setup_630: got %0d want 630", sx); end
    @(negedge clk);
    send_pkt(1'b0, 8'h48, 8'h00, 8'h00, 8'h00);
    checks++;
    if ({sintr, sx, sst} !== {1'b1, 10'd639, 8'h48}) begin
      errors++;
      $display("FAIL xovf_clamp: got intr=%b x=%0d st=%h want 1 639 48", sintr, sx, sst);
    end
    @(negedge clk);
  endtask

  task automatic test_sync();
    send_byte(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({ssync, sintr, sx, sy, sst} !== {1'b1, 1'b0, CW'(mx), CW'(my), ms}) begin
      errors++;
      $display("FAIL sync_drop: got sync=%b intr=%b x=%0d y=%0d st=%h want 1 0 %0d %0d %h",
               ssync, sintr, sx, sy, sst, mx, my, ms);
    end
    send_pkt(1'b0, 8'h09, 8'hFF, 8'h00, 8'h00);
    checks++;
    if ({sintr, sx, sst} !== {1'b1, 10'd639, 8'h09}) begin
      errors++;
      $display("FAIL after_sync: got intr=%b x=%0d st=%h want 1 639 09", sintr, sx, sst);
    end
    @(negedge clk);
  endtask

  task automatic test_error_abort();
    send_byte(1'b0, 8'h08, 1'b1, 1'b0);
    send_byte(1'b0, 8'h10, 1'b1, 1'b1);
    checks++;
    if ({ssync, sintr} !== 2'b10) begin
      errors++;
      $display("FAIL err_wins: got sync=%b intr=%b want 1 0", ssync, sintr);
    end
    send_pkt(1'b0, 8'h18, 8'hF0, 8'h00, 8'h00);
    checks++;
    if ({sintr, ssync, sx, sy, sst} !== {2'b10, CW'(mx), CW'(my), ms}) begin
      errors++;
      $display("FAIL after_err: got intr=%b sync=%b x=%0d y=%0d st=%h want 1 0 %0d %0d %h",
               sintr, ssync, sx, sy, sst, mx, my, ms);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  k;
    bit  seen;
    k = 0; seen = 1'b0;
    send_byte(1'b0, 8'h18, 1'b1, 1'b0);
    send_byte(1'b0, 8'h02, 1'b1, 1'b0);
    for (int i = 1; i <= int'(TO) + 5; i++) begin
      @(negedge clk);
      if (ssync) begin k = i; seen = 1'b1; break; end
    end
    checks++;
    if (!seen || k < int'(TO) - 1 || k > int'(TO) + 1) begin
      errors++;
      $display("FAIL timeout: got seen=%b after %0d cycles want about %0d", seen, k, TO);
    end
    send_pkt(1'b0, 8'h08, 8'h01, 8'h01, 8'h00);
    checks++;
    if ({sintr, sx, sy, sst} !== {1'b1, CW'(mx), CW'(my), ms}) begin
      errors++;
      $display("FAIL after_timeout: got intr=%b x=%0d y=%0d st=%h want 1 %0d %0d %h",
               sintr, sx, sy, sst, mx, my, ms);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2;
    for (int n = 0; n < 40; n++) begin
      b0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 5) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pkt(1'b0, b0, b1, b2, 8'h00);
      checks++;
      if ({sintr, sx, sy, sz, sst} !== {1'b1, CW'(mx), CW'(my), 8'd0, ms}) begin
        errors++;
        $display("FAIL rand_pkt %0d: got intr=%b x=%0d y=%0d z=%0d st=%h want 1 %0d %0d 0 %h",
                 n, sintr, sx, sy, sz, sst, mx, my, ms);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    send_byte(1'b0, 8'h08, 1'b1, 1'b0);
    send_byte(1'b0, 8'h10, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_home();
    checks++;
    if ({sintr, ssync, sx, sy, sst} !== {2'b00, 10'd320, 10'd240, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got intr=%b sync=%b x=%0d y=%0d st=%h want 0 0 320 240 00",
               sintr, ssync, sx, sy, sst);
    end
    send_pkt(1'b0, 8'h08, 8'h05, 8'h03, 8'h00);
    checks++;
    if ({sintr, ssync, sx, sy} !== {2'b10, 10'd325, 10'd237}) begin
      errors++;
      $display("FAIL post_reset_pkt: got intr=%b sync=%b x=%0d y=%0d want 1 0 325 237",
               sintr, ssync, sx, sy);
    end
    @(negedge clk);
  endtask

  task automatic test_wheel();
    logic [7:0] b0, b1, b2, b3;
    for (int n = 0; n < 200; n++) begin
      send_pkt(1'b1, 8'h08, 8'h00, 8'h00, 8'h0F);
      checks++;
      if ({wintr, wz_o} !== {1'b1, ZW'(wz)}) begin
        errors++;
        $display("FAIL wheel_down %0d: got intr=%b z=%0d want 1 %0d", n, wintr, $signed(wz_o), wz);
      end
      @(negedge clk);
    end
    checks++;
    if (wz_o !== 8'h80) begin errors++; $display("FAIL z_floor: got %0d want -128", $signed(wz_o)); end
    for (int n = 0; n < 30; n++) begin
      b0 = 8'($urandom) | 8'h08;
      b0[7:6] = 2'b00;
      b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      send_pkt(1'b1, b0, b1, b2, b3);
      checks++;
      if ({wintr, wx_o, wy_o, wz_o, wst} !== {1'b1, CW'(wx), CW'(wy), ZW'(wz), ws}) begin
        errors++;
        $display("FAIL wheel_rand %0d: got intr=%b x=%0d y=%0d z=%0d st=%h want 1 %0d %0d %0d %h",
                 n, wintr, wx_o, wy_o, $signed(wz_o), wst, wx, wy, wz, ws);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_centre_limits();
    send_byte(1'b0, 8'h08, 1'b1, 1'b0);
    send_byte(1'b0, 8'h20, 1'b1, 1'b0);
    ifs.BYTE_IN = 8'h00; ifs.BYTE_VALID = 1'b1; centre = 1'b1;
    @(negedge clk);
    ifs.BYTE_VALID = 1'b0; centre = 1'b0;
    checks++;
    if ({sintr, sx, sy, sz, sst} !== {1'b1, 10'd320, 10'd240, 8'd0, 8'h08}) begin
      errors++;
      $display("FAIL centre_update: got intr=%b x=%0d y=%0d z=%0d st=%h want 1 320 240 0 08",
               sintr, sx, sy, sz, sst);
    end
    checks++;
    if (wz_o !== 8'd0) begin errors++; $display("FAIL centre_z: got %0d want 0", $signed(wz_o)); end
    @(negedge clk);
    lim_x = 10'd100;
    @(negedge clk);
    checks++;
    if ({sintr, sx, sy} !== {1'b0, 10'd99, 10'd240}) begin
      errors++;
      $display("FAIL shrink_x: got intr=%b x=%0d y=%0d want 0 99 240", sintr, sx, sy);
    end
    lim_y = 10'd10;
    @(negedge clk);
    checks++;
    if ({sintr, sy} !== {1'b0, 10'd9}) begin
      errors++;
      $display("FAIL shrink_y: got intr=%b y=%0d want 0 9", sintr, sy);
    end
    lim_x = 10'd0;
    @(negedge clk);
    send_pkt(1'b0, 8'h08, 8'h40, 8'h00, 8'h00);
    checks++;
    if ({sintr, sx} !== {1'b1, 10'd0}) begin
      errors++;
      $display("FAIL zero_limit: got intr=%b x=%0d want 1 0", sintr, sx);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; centre = 1'b0; lim_x = 10'd640; lim_y = 10'd480;
    ifs.BYTE_IN = '0; ifs.BYTE_VALID = 1'b0; ifs.BYTE_ERROR = 1'b0;
    ifw.BYTE_IN = '0; ifw.BYTE_VALID = 1'b0; ifw.BYTE_ERROR = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_sync();
    test_error_abort();
    test_timeout();
    test_random();
    test_mid_reset();
    test_wheel();
    test_centre_limits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_pointer_tracker.md
Name: ps2_pointer_tracker

Overview:
- Parametrised successor to the mouse position pre-processor.
- Assembles raw PS/2 packet bytes from the mouse receiver into 3-byte (standard) or 4-byte (wheel) packets, with sync checking and an inter-byte timeout.
- Accumulates saturated X/Y/Z position against runtime-programmable screen limits, with sensitivity scaling and optional Y inversion.
- Sits between the mouse receiver byte stream and the bus/VGA consumers; raises INTR once per accepted packet.

Parameters:
- COORD_W, 10: width of MOUSE_X / MOUSE_Y (unsigned).
- Z_W, 8: width of MOUSE_Z (signed accumulator).
- WHEEL_EN, 0: 1 means 4-byte packets, byte 3 is the wheel delta.
- SENS_SHIFT, 0: deltas are arithmetic-shifted left by this amount before accumulation (0..3).
- INVERT_Y, 1: 1 means screen Y = position minus dy (PS/2 up is positive).
- TIMEOUT_CYC, 200000: CLK cycles allowed between bytes of one packet.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- BYTE_IN  in  8  received byte
- BYTE_VALID  in  1  one-cycle strobe, BYTE_IN valid
- BYTE_ERROR  in  1  one-cycle strobe, receiver parity/frame error
- LIMIT_X  in  COORD_W  X range is 0..LIMIT_X-1
- LIMIT_Y  in  COORD_W  Y range is 0..LIMIT_Y-1
- CENTRE  in  1  pulse: recentre X/Y, clear Z
- MOUSE_X  out  COORD_W  current X
- MOUSE_Y  out  COORD_W  current Y
- MOUSE_Z  out  Z_W  signed wheel accumulator
- MOUSE_STATUS  out  8  byte 0 of the last accepted packet
- INTR  out  1  one-cycle pulse per accepted packet
- SYNC_ERR  out  1  one-cycle pulse per discarded packet or byte

Behaviour:
- Reset values:
  - MOUSE_X = LIMIT_X>>1 and MOUSE_Y = LIMIT_Y>>1, sampled during reset.
  - MOUSE_Z = 0, MOUSE_STATUS = 0, INTR = 0, SYNC_ERR = 0.
  - FSM in WAIT_B0; timeout counter = 0.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, WAIT_B3 (WAIT_B3 exists only when WHEEL_EN=1), UPDATE.
  - WAIT_B0 with BYTE_VALID: if BYTE_IN[3]=1, latch byte 0 and go to WAIT_B1. Otherwise drop the byte, pulse SYNC_ERR and stay.
  - WAIT_B1 with BYTE_VALID: latch dx and go to WAIT_B2.
  - WAIT_B2 with BYTE_VALID: latch dy, then go to WAIT_B3 if WHEEL_EN=1, else UPDATE.
  - WAIT_B3 with BYTE_VALID: latch dz and go to UPDATE.
  - UPDATE lasts exactly one cycle. It registers the new outputs, pulses INTR in that same cycle, then returns to WAIT_B0.
  - Latency: INTR and the new outputs are visible on the cycle after the last byte's strobe.
- Abort conditions:
  - BYTE_ERROR in any WAIT state: go to WAIT_B0, pulse SYNC_ERR, discard the partial packet.
  - In WAIT_B1..B3, the counter increments each cycle and clears on BYTE_VALID. When it reaches TIMEOUT_CYC: go to WAIT_B0 and pulse SYNC_ERR.
  - BYTE_VALID and BYTE_ERROR in the same cycle: the error wins.
- Delta arithmetic:
  - dx9 = {status[4], byte1}, signed 9-bit.
  - If status[6] (X overflow) is set, dx9 = +255 when the sign bit is 0, or -256 when it is 1.
  - dy9 is formed the same way from status[5], status[7] and byte2.
  - dz = sign-extended byte3[3:0] (IntelliMouse 4-bit Z).
  - Scaled delta = delta <<< SENS_SHIFT, computed in COORD_W+SENS_SHIFT+2 signed bits, so there is no wrap.
- Position update:
  - X_new = X + dx_s; Y_new = Y − dy_s when INVERT_Y=1, else Y + dy_s.
  - Clamp: a result < 0 becomes 0; a result > LIMIT−1 becomes LIMIT−1. If LIMIT = 0, the position is forced to 0.
  - Z saturates at the Z_W signed min/max; it never wraps.
  - MOUSE_STATUS takes byte 0.
- CENTRE:
  - Acts in any state. The next cycle gives X = LIMIT_X>>1, Y = LIMIT_Y>>1, Z = 0.
  - If CENTRE coincides with UPDATE, centring wins for X/Y/Z. MOUSE_STATUS still updates and INTR still pulses.
- Runtime limit shrink: in any cycle where MOUSE_X > LIMIT_X−1, clamp MOUSE_X to LIMIT_X−1 on the next cycle, without INTR. MOUSE_Y is handled the same way.
- Mid-packet RESET: state, counter and partial bytes are cleared; no INTR and no SYNC_ERR are generated.

Decomposition:
- Shared package ps2_mouse_pkg:
  - FSM state encoding.
  - Status bit indices: YOVF=7, XOVF=6, YSIGN=5, XSIGN=4, SYNC=3, MID=2, RIGHT=1, LEFT=0.
  - PS/2 default packet lengths (3 and 4).
- One sub-module: ps2_axis_accum. It holds the signed delta, overflow saturation, shift, clamp and one axis register. It is instantiated twice (X, Y); Z uses a saturating-only variant selected by a CLAMP_EN parameter.

Test Plan:
- Setup: LIMIT_X=640, LIMIT_Y=480, reset, then bytes 0x08, 0x10, 0x05 -> INTR one cycle after byte 2; X=336, Y=235, STATUS=0x08.
- Bytes 0x48, 0x00, 0x00 (X overflow, positive) at X=630 -> X=639 (clamped), INTR pulses.
- Byte 0x00 first (sync bit clear) -> SYNC_ERR pulse, no state change; then valid packet 0x09, 0xFF, 0x00 (status 0x09 has sign bit clear, so dx=+255) -> INTR with X=min(prev+255, 639), STATUS=0x09 (left button).
- Bytes 0x18, 0x02, then silence for TIMEOUT_CYC cycles -> SYNC_ERR, FSM in WAIT_B0; the next 3 bytes form a clean packet.
- WHEEL_EN=1: bytes 0x08, 0, 0, 0x0F repeated 200 times -> MOUSE_Z saturates at −128, never wraps.
- CENTRE asserted in the UPDATE cycle of packet 0x08, 0x20, 0x00 -> X=320, Y=240, Z=0, STATUS=0x08, INTR=1; then LIMIT_X set to 100 -> X=99 next cycle, no INTR.
